// File: rtl/hangman_guess_ctrl.sv
// Hangman game-state controller: holds the secret word, checks one guessed letter
// code at a time, reveals matching slots and counts misses for the 7-segment decoders.
module hangman_guess_ctrl #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned MAX_MISS = 6
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [5*SLOTS-1:0]   word_in,
  input  logic                 guess_valid,
  input  logic [4:0]           guess,
  output logic                 guess_ready,
  output logic [5*SLOTS-1:0]   slot_code,
  output logic [SLOTS-1:0]     slot_en,
  output logic [2:0]           miss_count,
  output logic                 won,
  output logic                 lost
);

  localparam int unsigned CW = 5;
  localparam int unsigned WW = CW * SLOTS;
  localparam logic [2:0]  MISS_LIMIT = 3'(MAX_MISS);

  typedef enum logic [2:0] {IDLE, PLAY, CHECK, WON, LOST} state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     word_q, word_d;
  logic [SLOTS-1:0]  revealed_q, revealed_d;
  logic [31:0]       guessed_q, guessed_d;
  logic [2:0]        miss_q, miss_d;
  logic [4:0]        guess_q, guess_d;
  logic [SLOTS-1:0]  match;
  logic [SLOTS-1:0]  blank_mask;
  logic [SLOTS-1:0]  show;

  // Slots hit by the latched guess, and unused slots of the incoming word.
  always_comb begin
    match      = '0;
    blank_mask = '0;
    for (int i = 0; i < SLOTS; i++) begin
      match[i]      = (guess_q != 5'd0) && (word_q[CW*i +: CW] == guess_q);
      blank_mask[i] = (word_in[CW*i +: CW] == 5'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      word_q     <= '0;
      revealed_q <= '0;
      guessed_q  <= '0;
      miss_q     <= '0;
      guess_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      revealed_q <= revealed_d;
      guessed_q  <= guessed_d;
      miss_q     <= miss_d;
      guess_q    <= guess_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    revealed_d = revealed_q;
    guessed_d  = guessed_q;
    miss_d     = miss_q;
    guess_d    = guess_q;
    if (load) begin
      word_d     = word_in;
      revealed_d = blank_mask;
      guessed_d  = '0;
      miss_d     = '0;
      state_d    = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (guess_valid) begin
            guess_d = guess;
            state_d = CHECK;
          end
        end
        CHECK: begin
          // Code 0 and repeated letters leave the game untouched.
          if (guess_q != 5'd0 && !guessed_q[guess_q]) begin
            guessed_d[guess_q] = 1'b1;
            revealed_d         = revealed_q | match;
            if (match == '0 && miss_q < MISS_LIMIT) begin
              miss_d = miss_q + 3'd1;
            end
          end
          if (&revealed_d) begin
            state_d = WON;
          end else if (miss_d == MISS_LIMIT) begin
            state_d = LOST;
          end else begin
            state_d = PLAY;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode registered state only; a finished game shows the whole word.
  always_comb begin
    case (state_q)
      PLAY, CHECK: show = revealed_q;
      WON, LOST:   show = '1;
      default:     show = '0;
    endcase
    slot_code = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (show[i]) begin
        slot_code[CW*i +: CW] = word_q[CW*i +: CW];
      end
    end
  end

  assign slot_en     = show;
  assign guess_ready = (state_q == PLAY);
  assign miss_count  = miss_q;
  assign won         = (state_q == WON);
  assign lost        = (state_q == LOST);

endmodule

// File: tb/tb_hangman_guess_ctrl.sv
// Scoreboard bench for hangman_guess_ctrl: expected output snapshots are queued as
// stimulus is driven and compared against the DUT once the response is due.
module tb_hangman_guess_ctrl;

  localparam int unsigned SLOTS = 4;

  typedef struct packed {
    logic        ready;
    logic [3:0]  en;
    logic [19:0] code;
    logic [2:0]  miss;
    logic        won;
    logic        lost;
  } obs_t;

  localparam logic [19:0] W1 = {5'd4, 5'd1, 5'd20, 5'd3};
  localparam logic [19:0] W2 = {5'd2, 5'd0, 5'd5, 5'd6};

  logic        clock;
  logic        resetn;
  logic        load;
  logic [19:0] word_in;
  logic        guess_valid;
  logic [4:0]  guess;
  logic        guess_ready;
  logic [19:0] slot_code;
  logic [3:0]  slot_en;
  logic [2:0]  miss_count;
  logic        won;
  logic        lost;

  obs_t obs;
  obs_t sb[$];
  obs_t e;
  int   checks;
  int   failures;

  hangman_guess_ctrl #(.SLOTS(SLOTS), .MAX_MISS(6)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .load        (load),
    .word_in     (word_in),
    .guess_valid (guess_valid),
    .guess       (guess),
    .guess_ready (guess_ready),
    .slot_code   (slot_code),
    .slot_en     (slot_en),
    .miss_count  (miss_count),
    .won         (won),
    .lost        (lost)
  );

  assign obs = {guess_ready, slot_en, slot_code, miss_count, won, lost};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] shown(input logic [19:0] w, input logic [3:0] en);
    logic [19:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) if (en[i]) c[5*i +: 5] = w[5*i +: 5];
    return c;
  endfunction

  function automatic obs_t mk(input logic r, input logic [3:0] en, input logic [19:0] c,
                              input logic [2:0] m, input logic w, input logic l);
    obs_t o;
    o.ready = r; o.en = en; o.code = c; o.miss = m; o.won = w; o.lost = l;
    return o;
  endfunction

  // Stimulus only: tasks start just after a falling edge and end just after one.
  task automatic load_word(input logic [19:0] w);
    load = 1'b1; word_in = w;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic drive_guess(input logic [4:0] g);
    guess_valid = 1'b1; guess = g;
    @(negedge clock);
    guess_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; guess_valid = 1'b1; guess = 5'd5;
    repeat (2) @(negedge clock);
    sb.push_back(mk(0, 4'b0, 20'b0, 3'd0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset got=%h exp=%h", obs, e); end
    resetn = 1'b1;
    @(negedge clock);
    guess_valid = 1'b0;
    sb.push_back(mk(0, 4'b0, 20'b0, 3'd0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL idle_ignores_guess got=%h exp=%h", obs, e); end
  endtask

  task automatic test_reveal;
    load_word(W1);
    sb.push_back(mk(1, 4'b0, 20'b0, 3'd0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL load got=%h exp=%h", obs, e); end
    drive_guess(5'd1);
    sb.push_back(mk(1, 4'b0100, shown(W1, 4'b0100), 3'd0, 0, 0));
    checks++;
    if (guess_ready !== 1'b0) begin failures++; $display("FAIL ready_drop got=%b exp=0", guess_ready); end
    @(negedge clock);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reveal got=%h exp=%h", obs, e); end
  endtask

  task automatic test_miss;
    logic [4:0] gs [4] = '{5'd9, 5'd9, 5'd17, 5'd0};
    logic [2:0] ms [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
    for (int i = 0; i < 4; i++) begin
      drive_guess(gs[i]);
      sb.push_back(mk(1, 4'b0100, shown(W1, 4'b0100), ms[i], 0, 0));
      @(negedge clock);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL miss[%0d] got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_win;
    logic [4:0] gs [4] = '{5'd3, 5'd20, 5'd1, 5'd4};
    logic [3:0] en [4] = '{4'b0101, 4'b0111, 4'b0111, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      drive_guess(gs[i]);
      sb.push_back(mk(i != 3, en[i], shown(W1, en[i]), 3'd2, i == 3, 0));
      @(negedge clock);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL win[%0d] got=%h exp=%h", i, obs, e); end
    end
    drive_guess(5'd5);
    drive_guess(5'd6);
    sb.push_back(mk(0, 4'b1111, W1, 3'd2, 1, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL won_holds got=%h exp=%h", obs, e); end
  endtask

  task automatic test_lose;
    logic [4:0] gs [6] = '{5'd7, 5'd8, 5'd10, 5'd11, 5'd12, 5'd13};
    load_word(W1);
    for (int i = 0; i < 6; i++) begin
      drive_guess(gs[i]);
      if (i == 5) sb.push_back(mk(0, 4'b1111, W1, 3'd6, 0, 1));
      else        sb.push_back(mk(1, 4'b0000, 20'b0, 3'(i + 1), 0, 0));
      @(negedge clock);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL lose[%0d] got=%h exp=%h", i, obs, e); end
    end
    drive_guess(5'd14);
    @(negedge clock);
    sb.push_back(mk(0, 4'b1111, W1, 3'd6, 0, 1));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL lost_holds got=%h exp=%h", obs, e); end
    load_word(W2);
    sb.push_back(mk(1, 4'b0100, shown(W2, 4'b0100), 3'd0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reload got=%h exp=%h", obs, e); end
  endtask

  task automatic test_priority;
    load = 1'b1; word_in = W1; guess_valid = 1'b1; guess = 5'd4;
    @(negedge clock);
    load = 1'b0; guess_valid = 1'b0;
    sb.push_back(mk(1, 4'b0000, 20'b0, 3'd0, 0, 0));
    sb.push_back(mk(1, 4'b0000, 20'b0, 3'd0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL load_vs_guess got=%h exp=%h", obs, e); end
    @(negedge clock);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL guess_dropped got=%h exp=%h", obs, e); end
    drive_guess(5'd9);
    load_word(W2);
    sb.push_back(mk(1, 4'b0100, 20'b0, 3'd0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL load_in_check got=%h exp=%h", obs, e); end
    drive_guess(5'd9);
    @(negedge clock);
    sb.push_back(mk(1, 4'b0100, 20'b0, 3'd1, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL mask_cleared got=%h exp=%h", obs, e); end
    drive_guess(5'd6);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    sb.push_back(mk(0, 4'b0, 20'b0, 3'd0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_in_check got=%h exp=%h", obs, e); end
  endtask

  task automatic test_all_zero;
    load_word(20'b0);
    sb.push_back(mk(1, 4'b1111, 20'b0, 3'd0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL zero_load got=%h exp=%h", obs, e); end
    drive_guess(5'd0);
    sb.push_back(mk(0, 4'b1111, 20'b0, 3'd0, 1, 0));
    @(negedge clock);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL zero_win got=%h exp=%h", obs, e); end
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0; load = 1'b0; word_in = '0; guess_valid = 1'b0; guess = '0;
    test_reset();
    test_reveal();
    test_miss();
    test_win();
    test_lose();
    test_priority();
    test_all_zero();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
